// File: rtl/pong_pkg.sv
// Purpose: shared constants and types for the pong design (button indices, clock, video timing).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pong_pkg;

   // Button bit positions, shared by the conditioner and the video generator
   localparam int BTN_L_UP = 0;
   localparam int BTN_L_DN = 1;
   localparam int BTN_R_UP = 2;
   localparam int BTN_R_DN = 3;
   localparam int NUM_BTN  = 4;

   localparam int CLK_HZ   = 25_175_000;

   // 640x480@60 video timing
   localparam int H_VISIBLE = 640;
   localparam int H_FRONT   = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BACK    = 48;
   localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_VISIBLE = 480;
   localparam int V_FRONT   = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BACK    = 33;
   localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   // Per-button auto-repeat state
   typedef enum logic [1:0] {
      RPT_IDLE   = 2'd0,
      RPT_DELAY  = 2'd1,
      RPT_REPEAT = 2'd2
   } rpt_state_t;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Counter width for a modulo-n counter, never below 1 bit
   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pong_button_conditioner_if.sv
// Purpose: button-conditioner bus: raw buttons and frame tick in, debounced levels and step pulses out.
// Latency: n/a (wiring only).
// Backpressure: none; step pulses are fire-and-forget.
//   btn_raw    : async raw buttons, active-high
//   frame_tick : 1-cycle pulse per video frame
//   held       : debounced button levels
//   step       : 1-cycle step pulses, same bit order as btn_raw
interface pong_button_conditioner_if;
   import pong_pkg::*;

   logic [NUM_BTN-1:0] btn_raw;
   logic               frame_tick;
   logic [NUM_BTN-1:0] held;
   logic [NUM_BTN-1:0] step;

   modport master (output btn_raw, output frame_tick, input held, input step);
   modport slave  (input btn_raw, input frame_tick, output held, output step);

endinterface

// File: rtl/pong_btn_channel.sv
// Purpose: one button: 2-flop sync, tick-based debounce, press pulse plus frame-aligned auto-repeat.
// Latency: raw -> held 2 clk + DEBOUNCE_TICKS ms ticks; held rise -> press step 1 clk.
// Backpressure: none; o_step is a registered 1-cycle pulse.
//   clk, rst     : clock, synchronous active-high reset
//   i_btn_raw    : asynchronous raw button
//   i_ms_tick    : shared debounce tick
//   i_frame_tick : shared frame pulse
//   o_held       : debounced level
//   o_step       : step pulse (unmasked)
module pong_btn_channel
   import pong_pkg::*;
#(
   parameter int DEBOUNCE_TICKS = 10,
   parameter int REPEAT_DELAY   = 20,
   parameter int REPEAT_PERIOD  = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_btn_raw,
   input  logic i_ms_tick,
   input  logic i_frame_tick,
   output logic o_held,
   output logic o_step
);

   localparam int DCNT_W = cnt_w(DEBOUNCE_TICKS);
   localparam int FCNT_W = $clog2(max2(REPEAT_DELAY, REPEAT_PERIOD) + 1);
   localparam logic [DCNT_W-1:0] DCNT_LAST   = DCNT_W'(DEBOUNCE_TICKS - 1);
   localparam logic [FCNT_W-1:0] DELAY_LAST  = FCNT_W'(REPEAT_DELAY - 1);
   localparam logic [FCNT_W-1:0] PERIOD_LAST = FCNT_W'(REPEAT_PERIOD - 1);

   logic              r_sync1;
   logic              r_sync2;
   logic              r_held;
   logic [DCNT_W-1:0] r_dcnt;

   rpt_state_t        r_state;
   rpt_state_t        w_state_nxt;
   logic [FCNT_W-1:0] r_fcnt;
   logic [FCNT_W-1:0] w_fcnt_nxt;
   logic              r_step;
   logic              w_step_nxt;
   logic [FCNT_W-1:0] w_fcnt_last;

   // Synchroniser and debouncer. Any tick where the synced input agrees with
   // the debounced level restarts the run, so only an unbroken run flips it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_held  <= 1'b0;
         r_dcnt  <= '0;
      end else begin
         r_sync1 <= i_btn_raw;
         r_sync2 <= r_sync1;
         if (i_ms_tick) begin
            if (r_sync2 == r_held) begin
               r_dcnt <= '0;
            end else if (r_dcnt == DCNT_LAST) begin
               r_held <= ~r_held;
               r_dcnt <= '0;
            end else begin
               r_dcnt <= r_dcnt + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= RPT_IDLE;
         r_fcnt  <= '0;
         r_step  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_fcnt  <= w_fcnt_nxt;
         r_step  <= w_step_nxt;
      end
   end

   assign w_fcnt_last = (r_state == RPT_DELAY) ? DELAY_LAST : PERIOD_LAST;

   // IDLE always means held was low last cycle, so IDLE with held high is the
   // rising edge; any frame_tick in that cycle is deliberately dropped.
   always_comb begin
      w_state_nxt = r_state;
      w_fcnt_nxt  = r_fcnt;
      w_step_nxt  = 1'b0;
      case (r_state)
         RPT_IDLE: begin
            if (r_held) begin
               w_state_nxt = RPT_DELAY;
               w_fcnt_nxt  = '0;
               w_step_nxt  = 1'b1;
            end
         end
         RPT_DELAY, RPT_REPEAT: begin
            if (!r_held) begin
               w_state_nxt = RPT_IDLE;
               w_fcnt_nxt  = '0;
            end else if (i_frame_tick) begin
               if (r_fcnt == w_fcnt_last) begin
                  w_state_nxt = RPT_REPEAT;
                  w_fcnt_nxt  = '0;
                  w_step_nxt  = 1'b1;
               end else begin
                  w_fcnt_nxt = r_fcnt + 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = RPT_IDLE;
            w_fcnt_nxt  = '0;
         end
      endcase
   end

   assign o_held = r_held;
   assign o_step = r_step;

endmodule

// File: rtl/pong_button_conditioner.sv
// Purpose: paddle button input stage: ms prescaler, four button channels, up/down conflict masking.
// Latency: raw -> held 2 clk + DEBOUNCE_TICKS ticks (+ up to TICK_DIV clk phase); held rise -> step 1 clk.
// Backpressure: none; steps are single-cycle pulses the video generator must take as they come.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of pong_button_conditioner_if (btn_raw, frame_tick in; held, step out)
module pong_button_conditioner
   import pong_pkg::*;
#(
   parameter int TICK_DIV       = CLK_HZ / 1000,
   parameter int DEBOUNCE_TICKS = 10,
   parameter int REPEAT_DELAY   = 20,
   parameter int REPEAT_PERIOD  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   pong_button_conditioner_if.slave   bus
);

   localparam int PRE_W = cnt_w(TICK_DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

   logic [PRE_W-1:0]   r_presc;
   logic               w_ms_tick;
   logic [NUM_BTN-1:0] w_held;
   logic [NUM_BTN-1:0] w_step;
   logic [NUM_BTN-1:0] w_step_masked;
   logic               w_l_conflict;
   logic               w_r_conflict;

   assign w_ms_tick = (r_presc == PRE_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_presc <= '0;
      end else if (w_ms_tick) begin
         r_presc <= '0;
      end else begin
         r_presc <= r_presc + 1'b1;
      end
   end

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
      pong_btn_channel #(
         .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_PERIOD  (REPEAT_PERIOD)
      ) u_ch (
         .clk          (clk),
         .rst          (rst),
         .i_btn_raw    (bus.btn_raw[g]),
         .i_ms_tick    (w_ms_tick),
         .i_frame_tick (bus.frame_tick),
         .o_held       (w_held[g]),
         .o_step       (w_step[g])
      );
   end

   // Up+down together on one paddle means "don't move". Only the output is
   // masked: the channels keep their repeat phase so releasing one button
   // resumes the other on its next due frame.
   assign w_l_conflict = w_held[BTN_L_UP] & w_held[BTN_L_DN];
   assign w_r_conflict = w_held[BTN_R_UP] & w_held[BTN_R_DN];

   always_comb begin
      w_step_masked = w_step;
      if (w_l_conflict) begin
         w_step_masked[BTN_L_UP] = 1'b0;
         w_step_masked[BTN_L_DN] = 1'b0;
      end
      if (w_r_conflict) begin
         w_step_masked[BTN_R_UP] = 1'b0;
         w_step_masked[BTN_R_DN] = 1'b0;
      end
   end

   assign bus.held = w_held;
   assign bus.step = w_step_masked;

endmodule
